// File: rtl/iter_mul_div_unit_if.sv
// Handshake/operand bundle for iter_mul_div_unit; master drives requests, slave returns results.
interface iter_mul_div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic                   sel_mul_div;
   logic                   signed_i;
   logic [WIDTH-1:0]       opdata1_i;
   logic [WIDTH-1:0]       opdata2_i;
   logic                   start_i;
   logic                   annul_i;
   logic [2*WIDTH-1:0]     result_o;
   logic                   ready_o;
   logic                   busy_o;
   logic                   div0_o;

   modport master (
      output sel_mul_div, signed_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, busy_o, div0_o
   );

   modport slave (
      input  sel_mul_div, signed_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, busy_o, div0_o
   );
endinterface

// File: rtl/iter_mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up, annul and div-by-zero.
// Optional MUL_DIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier is zero.
module iter_mul_div_unit #(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input logic                clk,
   input logic                rst,
   iter_mul_div_unit_if.slave bus
);

   localparam int unsigned W2 = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state_q;
   logic             mul_q, sa_q, sb_q, div0_q;
   logic [CNT_W-1:0] cnt_q;
   logic [W2-1:0]    acc_q, mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [W2-1:0]    result_q;
   logic             ready_q, div0_out_q;

   logic [WIDTH-1:0] mag1, mag2;
   logic [W2-1:0]    acc_d, mcand_d;
   logic [WIDTH-1:0] mplier_d;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] divisor, rem_sub, quo, rem;
   logic             rem_ge, last_d;
   logic [W2-1:0]    fix_res;

   assign mag1 = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
   assign mag2 = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

   // acc_q holds the product in multiply mode and the {rem, quo} pair in divide mode
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
      divisor  = mcand_q[WIDTH-1:0];
      rem_ge   = (rem_sh >= {1'b0, divisor});
      rem_sub  = rem_sh[WIDTH-1:0] - divisor;
      if (mul_q) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end else begin
         acc_d = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
      end
      last_d = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MUL_DIV_EARLY_OUT_EN
      if (mul_q && (mplier_d == '0)) last_d = 1'b1;
`endif
   end

   always_comb begin
      quo = acc_q[WIDTH-1:0];
      rem = acc_q[W2-1:WIDTH];
      if (mul_q)       fix_res = (sa_q ^ sb_q) ? -acc_q : acc_q;
      else if (div0_q) fix_res = acc_q;
      else             fix_res = {(sa_q ? -rem : rem), ((sa_q ^ sb_q) ? -quo : quo)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mul_q      <= 1'b0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         div0_q     <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         result_q   <= '0;
         ready_q    <= 1'b0;
         div0_out_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (bus.annul_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start_i) begin
                     mul_q  <= bus.sel_mul_div;
                     sa_q   <= bus.signed_i & bus.opdata1_i[WIDTH-1];
                     sb_q   <= bus.signed_i & bus.opdata2_i[WIDTH-1];
                     cnt_q  <= '0;
                     div0_q <= 1'b0;
                     if (bus.sel_mul_div) begin
                        acc_q    <= '0;
                        mcand_q  <= W2'(mag1);
                        mplier_q <= mag2;
                        state_q  <= CALC;
`ifdef MUL_DIV_EARLY_OUT_EN
                        if (mag2 == '0) state_q <= FIX;
`endif
                     end else if (bus.opdata2_i == '0) begin
                        div0_q  <= 1'b1;
                        acc_q   <= {bus.opdata1_i, {WIDTH{1'b1}}};
                        state_q <= FIX;
                     end else begin
                        acc_q   <= W2'(mag1);
                        mcand_q <= W2'(mag2);
                        state_q <= CALC;
                     end
                  end
               end
               CALC: begin
                  acc_q    <= acc_d;
                  mcand_q  <= mcand_d;
                  mplier_q <= mplier_d;
                  if (last_d) begin
                     cnt_q   <= '0;
                     state_q <= FIX;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               FIX: begin
                  result_q   <= fix_res;
                  div0_out_q <= div0_q;
                  ready_q    <= 1'b1;
                  state_q    <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;
   assign bus.busy_o   = (state_q != IDLE);
   assign bus.div0_o   = div0_out_q;

endmodule

// File: tb/tb_iter_mul_div_unit.sv
// Self-checking bench for iter_mul_div_unit (WIDTH=32): vector table, corner sequences, random vs. model.
module tb_iter_mul_div_unit;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   iter_mul_div_unit_if #(.WIDTH(W)) bus ();
   iter_mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      bit          mul;
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] r;
      bit          d0;
      string       nm;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain arithmetic on 64-bit integers; SV division truncates toward zero like MIPS
   function automatic void model(input bit mul, input bit sgn, input logic [31:0] a,
                                 input logic [31:0] b, output logic [63:0] r, output bit d0);
      longint sa, sb, q, rm;
      d0 = 1'b0;
      sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      if (mul) begin
         q = sa * sb;
         r = q;
      end else if (b == 0) begin
         r  = {a, 32'hFFFF_FFFF};
         d0 = 1'b1;
      end else begin
         q  = sa / sb;
         rm = sa % sb;
         r  = {rm[31:0], q[31:0]};
      end
   endfunction

   // Edge (start accept = 0) after which ready_o is expected high
   function automatic int unsigned exp_lat(input bit mul, input logic [31:0] mb);
      if (!mul && mb == 0) return 1;
`ifdef MUL_DIV_EARLY_OUT_EN
      if (mul) begin
         int unsigned n;
         if (mb == 0) return 1;
         n = 0;
         for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
         return n + 1;
      end
`endif
      return W + 1;
   endfunction

   task automatic run_op(input string nm, input bit mul, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] er, input bit ed0);
      int unsigned lat, el;
      bit busy_ok;
      logic [31:0] mb;
      mb = (sgn && b[31]) ? -b : b;
      el = exp_lat(mul, mb);
      bus.sel_mul_div = mul;
      bus.signed_i    = sgn;
      bus.opdata1_i   = a;
      bus.opdata2_i   = b;
      bus.start_i     = 1'b1;
      wait_edge();
      chk({nm, "_busy_acc"}, 64'(bus.busy_o), 64'(1));
      // inputs change while busy; start stays high one more edge and must be ignored
      bus.opdata1_i   = $urandom;
      bus.opdata2_i   = $urandom;
      bus.sel_mul_div = ~mul;
      bus.signed_i    = ~sgn;
      lat = 0;
      busy_ok = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         wait_edge();
         if (k == 1) bus.start_i = 1'b0;
         if (bus.ready_o) begin
            lat = k;
            break;
         end
         if (!bus.busy_o) busy_ok = 1'b0;
      end
      chk({nm, "_latency"}, 64'(lat), 64'(el));
      chk({nm, "_busy_hold"}, 64'(busy_ok), 64'(1));
      chk({nm, "_result"}, bus.result_o, er);
      chk({nm, "_div0"}, 64'(bus.div0_o), 64'(ed0));
      chk({nm, "_busy_at_ready"}, 64'(bus.busy_o), 64'(0));
      wait_edge();
      chk({nm, "_ready_pulse"}, 64'(bus.ready_o), 64'(0));
      chk({nm, "_result_hold"}, bus.result_o, er);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] prev, er;
      bit seen, ed0;
      logic [31:0] ra, rb;
      bit rm, rs;

      tbl[0] = '{1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "mul_u_max"};
      tbl[1] = '{1, 1, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 0, "mul_s_m3x7"};
      tbl[2] = '{1, 0, 32'hFFFF_FFFD, 32'd7,         64'h0000_0006_FFFF_FFEB, 0, "mul_u_m3x7"};
      tbl[3] = '{0, 1, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 0, "div_s_m7d2"};
      tbl[4] = '{0, 0, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 0, "div_u_100d7"};
      tbl[5] = '{0, 0, 32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF, 1, "div0"};
      tbl[6] = '{0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, "div_s_ovf"};
      tbl[7] = '{1, 0, 32'd6,         32'd7,         64'd42,                  0, "mul_6x7"};
      tbl[8] = '{0, 1, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, "div_s_7dm2"};
      tbl[9] = '{1, 0, 32'd5,         32'd3,         64'd15,                  0, "mul_5x3"};

      bus.sel_mul_div = 1'b0;
      bus.signed_i    = 1'b0;
      bus.opdata1_i   = '0;
      bus.opdata2_i   = '0;
      bus.start_i     = 1'b0;
      bus.annul_i     = 1'b0;

      #2 rst = 1'b1;
      wait_edge();
      wait_edge();
      chk("rst_result", bus.result_o, 64'd0);
      chk("rst_flags", {61'd0, bus.ready_o, bus.busy_o, bus.div0_o}, 64'd0);
      rst = 1'b0;
      wait_edge();

      for (int i = 0; i < 10; i++)
         run_op(tbl[i].nm, tbl[i].mul, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].d0);

      // annul at counter 10 together with start; later start must run normally
      prev = bus.result_o;
      seen = 1'b0;
      bus.sel_mul_div = 1'b1; bus.signed_i = 1'b0;
      bus.opdata1_i = 32'h1234; bus.opdata2_i = 32'hFFFF_FFFF;
      bus.start_i = 1'b1;
      wait_edge();
      bus.start_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         wait_edge();
         seen |= bus.ready_o;
      end
      bus.annul_i = 1'b1;
      bus.start_i = 1'b1;
      wait_edge();
      chk("annul_busy_low", 64'(bus.busy_o), 64'(0));
      seen |= bus.ready_o;
      wait_edge();
      chk("annul_start_ignored", 64'(bus.busy_o), 64'(0));
      seen |= bus.ready_o;
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wait_edge();
         seen |= bus.ready_o;
      end
      chk("annul_no_ready", 64'(seen), 64'(0));
      chk("annul_result_kept", bus.result_o, prev);
      run_op("after_annul_6x7", 1, 0, 32'd6, 32'd7, 64'd42, 0);

      // annul while in FIX suppresses both the pulse and the write
      prev = bus.result_o;
      seen = 1'b0;
      bus.sel_mul_div = 1'b0; bus.signed_i = 1'b0;
      bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
      bus.start_i = 1'b1;
      wait_edge();
      bus.start_i = 1'b0;
      for (int k = 1; k <= W; k++) begin
         wait_edge();
         seen |= bus.ready_o;
      end
      chk("fix_busy", 64'(bus.busy_o), 64'(1));
      bus.annul_i = 1'b1;
      wait_edge();
      seen |= bus.ready_o;
      chk("fix_annul_busy", 64'(bus.busy_o), 64'(0));
      bus.annul_i = 1'b0;
      wait_edge();
      seen |= bus.ready_o;
      chk("fix_annul_no_ready", 64'(seen), 64'(0));
      chk("fix_annul_result", bus.result_o, prev);

      // asynchronous reset mid-CALC
      bus.sel_mul_div = 1'b1; bus.signed_i = 1'b0;
      bus.opdata1_i = 32'hFFFF; bus.opdata2_i = 32'hFFFF_FFFF;
      bus.start_i = 1'b1;
      wait_edge();
      bus.start_i = 1'b0;
      for (int k = 0; k < 5; k++) wait_edge();
      rst = 1'b1;
      #1;
      chk("midrst_result", bus.result_o, 64'd0);
      chk("midrst_flags", {61'd0, bus.ready_o, bus.busy_o, bus.div0_o}, 64'd0);
      wait_edge();
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         wait_edge();
         seen |= bus.ready_o | bus.busy_o;
      end
      chk("midrst_quiet", 64'(seen), 64'(0));

      for (int i = 0; i < 40; i++) begin
         rm = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'hFFFF_FFFF;
            3: rb = 32'h8000_0000;
            default: rb = $urandom;
         endcase
         ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         model(rm, rs, ra, rb, er, ed0);
         run_op($sformatf("rand%0d", i), rm, rs, ra, rb, er, ed0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
